// File: rtl/shreg_pkg.sv
// Shared types and helpers for the universal shift register slice.
// Command codes, controller states and the shift-count width function live here.
package shreg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bits needed to hold a shift amount from 0 up to and including width.
  function automatic int shreg_cw(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shreg_ctrl.sv
// Command controller for shreg_universal: IDLE/SHIFT/DONE sequencer,
// saturating step counter and registered busy/done decode.
// A command is accepted whenever the controller is not mid-shift, so a new
// command issued during the DONE cycle follows without a bubble.
module shreg_ctrl
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = shreg_cw(WIDTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [2:0]    i_mode,
  input  logic [CW-1:0] i_amount,
  output logic          o_accept,
  output logic          o_step_en,
  output logic [2:0]    o_mode,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [CW-1:0] WIDTH_CNT = CW'(WIDTH);
  localparam logic [CW-1:0] ONE_CNT   = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    mode_q, mode_d;
  logic [CW-1:0] amount_sat;
  logic          is_shift;

  assign o_accept   = i_start && (state_q != ST_SHIFT);
  assign is_shift   = (i_mode == MODE_SHL) || (i_mode == MODE_SHR) ||
                      (i_mode == MODE_ROL) || (i_mode == MODE_ROR);
  assign amount_sat = (i_amount > WIDTH_CNT) ? WIDTH_CNT : i_amount;

  // Next-state logic: count down one step per SHIFT cycle, then accept new work.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mode_d  = mode_q;
    case (state_q)
      ST_SHIFT: begin
        count_d = count_q - ONE_CNT;
        if (count_q == ONE_CNT) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (o_accept) begin
      mode_d = i_mode;
      if (is_shift) begin
        count_d = amount_sat;
        state_d = (amount_sat == '0) ? ST_DONE : ST_SHIFT;
      end else begin
        count_d = '0;
        state_d = ST_DONE;
      end
    end
  end

  // State registers; reset discards any command in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      mode_q  <= MODE_HOLD;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mode_q  <= mode_d;
    end
  end

  assign o_step_en = (state_q == ST_SHIFT);
  assign o_busy    = (state_q == ST_SHIFT);
  assign o_done    = (state_q == ST_DONE);
  assign o_mode    = mode_q;

endmodule

// File: rtl/shreg_universal.sv
// Parametrised universal shift register: parallel load, logical shifts with
// serial inputs, and rotates, with multi-bit shifts sequenced one bit per cycle.
// Build option SHREG_ROTATE_EN: when defined, ROL/ROR rotate; when undefined
// they degrade to SHL/SHR using the serial inputs and no rotate path exists.
module shreg_universal
  import shreg_pkg::*;
#(
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int               CW        = shreg_cw(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_mode,
  input  logic [CW-1:0]    i_amount,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_sin_r,
  input  logic             i_sin_l,
  output logic [WIDTH-1:0] o_q,
  output logic             o_sout_l,
  output logic             o_sout_r,
  output logic             o_busy,
  output logic             o_done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             accept;
  logic             step_en;
  logic [2:0]       shift_mode;

  shreg_ctrl #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_ctrl (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_mode    (i_mode),
    .i_amount  (i_amount),
    .o_accept  (accept),
    .o_step_en (step_en),
    .o_mode    (shift_mode),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  // Datapath mux: load on an accepted LOAD, otherwise one step per SHIFT cycle.
  always_comb begin
    q_d = q_q;
    if (accept && (i_mode == MODE_LOAD)) begin
      q_d = i_d;
    end else if (step_en) begin
      case (shift_mode)
        MODE_SHL: q_d = {q_q[WIDTH-2:0], i_sin_r};
        MODE_SHR: q_d = {i_sin_l, q_q[WIDTH-1:1]};
`ifdef SHREG_ROTATE_EN
        MODE_ROL: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_ROR: q_d = {q_q[0], q_q[WIDTH-1:1]};
`else
        MODE_ROL: q_d = {q_q[WIDTH-2:0], i_sin_r};
        MODE_ROR: q_d = {i_sin_l, q_q[WIDTH-1:1]};
`endif
        default:  q_d = q_q;
      endcase
    end
  end

  // Data register with asynchronous reset to the configured value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign o_q      = q_q;
  assign o_sout_l = q_q[WIDTH-1];
  assign o_sout_r = q_q[0];

endmodule

// File: tb/tb_shreg_universal.sv
// Self-checking bench for shreg_universal (WIDTH=8). A reference model pushes
// the expected per-cycle register/busy/done values into a scoreboard queue when
// a command is issued; each scenario task pops and compares after every edge.
module tb_shreg_universal;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [2:0]    i_mode;
  logic [CW-1:0] i_amount;
  logic [W-1:0]  i_d;
  logic          i_sin_r;
  logic          i_sin_l;
  logic [W-1:0]  o_q;
  logic          o_sout_l;
  logic          o_sout_r;
  logic          o_busy;
  logic          o_done;

  typedef struct packed {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] model_q;
  int           n_checks = 0;
  int           n_fail   = 0;

  shreg_universal #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_mode   (i_mode),
    .i_amount (i_amount),
    .i_d      (i_d),
    .i_sin_r  (i_sin_r),
    .i_sin_l  (i_sin_l),
    .o_q      (o_q),
    .o_sout_l (o_sout_l),
    .o_sout_r (o_sout_r),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  // 100 MHz-style free-running clock.
  always #5 i_clk = ~i_clk;

  // Hard stop in case something stalls the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired: actual=timeout required=completion");
    $fatal(1, "[TB] watchdog");
  end

  // Reference one-bit step of the register.
  function automatic logic [W-1:0] model_step(input logic [W-1:0] q, input logic [2:0] mode);
    logic [W-1:0] r;
    r = q;
    case (mode)
      3'b010: r = {q[W-2:0], i_sin_r};
      3'b011: r = {i_sin_l, q[W-1:1]};
`ifdef SHREG_ROTATE_EN
      3'b100: r = {q[W-2:0], q[W-1]};
      3'b101: r = {q[0], q[W-1:1]};
`else
      3'b100: r = {q[W-2:0], i_sin_r};
      3'b101: r = {i_sin_l, q[W-1:1]};
`endif
      default: r = q;
    endcase
    return r;
  endfunction

  // Drive one command for the next edge and push its expected cycle trace.
  task automatic push_cmd(input logic [2:0] mode, input int amt, input logic [W-1:0] d);
    int n;
    i_start  = 1'b1;
    i_mode   = mode;
    i_amount = CW'(amt);
    i_d      = d;
    if (mode == 3'b001) model_q = d;
    n = 0;
    if (mode >= 3'b010 && mode <= 3'b101) n = (amt > W) ? W : amt;
    if (n == 0) begin
      exp_q.push_back('{q: model_q, busy: 1'b0, done: 1'b1});
    end else begin
      exp_q.push_back('{q: model_q, busy: 1'b1, done: 1'b0});
      for (int k = 1; k <= n; k++) begin
        model_q = model_step(model_q, mode);
        exp_q.push_back('{q: model_q, busy: (k < n), done: (k == n)});
      end
    end
  endtask

  // Expect the register to sit idle for one cycle.
  task automatic push_idle();
    exp_q.push_back('{q: model_q, busy: 1'b0, done: 1'b0});
  endtask

  task automatic test_reset();
    exp_t e;
    i_rst = 1'b1; i_start = 1'b0; i_mode = 3'b000; i_amount = '0;
    i_d = '0; i_sin_r = 1'b0; i_sin_l = 1'b0;
    #2;
    n_checks++;
    if ({o_q, o_busy, o_done} !== {8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset_state: actual q=%h busy=%b done=%b required q=00 busy=0 done=0", o_q, o_busy, o_done);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    model_q = 8'h00;
    push_idle();
    while (exp_q.size() > 0) begin
      @(posedge i_clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({o_q, o_busy, o_done} !== {e.q, e.busy, e.done}) begin
        n_fail++;
        $display("[TB] FAIL reset_idle: actual q=%h b=%b d=%b required q=%h b=%b d=%b", o_q, o_busy, o_done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_load();
    exp_t e;
    @(negedge i_clk);
    push_cmd(3'b001, 0, 8'hA5);
    push_idle();
    while (exp_q.size() > 0) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if ({o_q, o_busy, o_done, o_sout_l, o_sout_r} !== {e.q, e.busy, e.done, e.q[W-1], e.q[0]}) begin
        n_fail++;
        $display("[TB] FAIL load: actual q=%h b=%b d=%b required q=%h b=%b d=%b", o_q, o_busy, o_done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_shift_left();
    exp_t e;
    i_sin_r = 1'b1;
    push_cmd(3'b010, 3, 8'h00);
    push_idle();
    while (exp_q.size() > 0) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if ({o_q, o_busy, o_done, o_sout_l, o_sout_r} !== {e.q, e.busy, e.done, e.q[W-1], e.q[0]}) begin
        n_fail++;
        $display("[TB] FAIL shl3: actual q=%h b=%b d=%b required q=%h b=%b d=%b", o_q, o_busy, o_done, e.q, e.busy, e.done);
      end
    end
    n_checks++;
    if (o_q !== 8'h2F) begin
      n_fail++;
      $display("[TB] FAIL shl3_final: actual q=%h required q=2f", o_q);
    end
    i_sin_r = 1'b0;
  endtask

  task automatic test_shift_right();
    exp_t e;
    i_sin_l = 1'b0;
    push_cmd(3'b001, 0, 8'h81);
    @(posedge i_clk); #1; i_start = 1'b0;
    void'(exp_q.pop_front());
    push_cmd(3'b011, 2, 8'h00);
    i_sin_l = 1'b0;
    while (exp_q.size() > 0) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if ({o_q, o_busy, o_done} !== {e.q, e.busy, e.done}) begin
        n_fail++;
        $display("[TB] FAIL shr2: actual q=%h b=%b d=%b required q=%h b=%b d=%b", o_q, o_busy, o_done, e.q, e.busy, e.done);
      end
    end
    n_checks++;
    if (o_q !== 8'h20) begin
      n_fail++;
      $display("[TB] FAIL shr2_final: actual q=%h required q=20", o_q);
    end
    push_cmd(3'b001, 0, 8'h81);
    @(posedge i_clk); #1; i_start = 1'b0;
    void'(exp_q.pop_front());
    i_sin_l = 1'b1;
    push_cmd(3'b011, 12, 8'h00);
    while (exp_q.size() > 0) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if ({o_q, o_busy, o_done} !== {e.q, e.busy, e.done}) begin
        n_fail++;
        $display("[TB] FAIL shr_sat: actual q=%h b=%b d=%b required q=%h b=%b d=%b", o_q, o_busy, o_done, e.q, e.busy, e.done);
      end
    end
    n_checks++;
    if (o_q !== 8'hFF) begin
      n_fail++;
      $display("[TB] FAIL shr_sat_final: actual q=%h required q=ff", o_q);
    end
    i_sin_l = 1'b0;
  endtask

  task automatic test_rotate();
    exp_t e;
    logic [W-1:0] want;
    i_sin_l = 1'b0;
    i_sin_r = 1'b1;
`ifdef SHREG_ROTATE_EN
    want = 8'hC3;
`else
    want = 8'h03;
`endif
    push_cmd(3'b001, 0, 8'h3C);
    @(posedge i_clk); #1; i_start = 1'b0;
    void'(exp_q.pop_front());
    push_cmd(3'b101, 4, 8'h00);
    while (exp_q.size() > 0) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if ({o_q, o_busy, o_done} !== {e.q, e.busy, e.done}) begin
        n_fail++;
        $display("[TB] FAIL ror4: actual q=%h b=%b d=%b required q=%h b=%b d=%b", o_q, o_busy, o_done, e.q, e.busy, e.done);
      end
    end
    n_checks++;
    if (o_q !== want) begin
      n_fail++;
      $display("[TB] FAIL ror4_final: actual q=%h required q=%h", o_q, want);
    end
    push_cmd(3'b100, 3, 8'h00);
    push_idle();
    while (exp_q.size() > 0) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if ({o_q, o_busy, o_done} !== {e.q, e.busy, e.done}) begin
        n_fail++;
        $display("[TB] FAIL rol3: actual q=%h b=%b d=%b required q=%h b=%b d=%b", o_q, o_busy, o_done, e.q, e.busy, e.done);
      end
    end
    i_sin_r = 1'b0;
  endtask

  task automatic test_zero_and_hold();
    exp_t e;
    logic [2:0] modes [3];
    modes[0] = 3'b010;
    modes[1] = 3'b000;
    modes[2] = 3'b110;
    for (int m = 0; m < 3; m++) begin
      push_cmd(modes[m], (m == 0) ? 0 : 5, 8'hE7);
      push_idle();
      while (exp_q.size() > 0) begin
        @(posedge i_clk); #1;
        i_start = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if ({o_q, o_busy, o_done} !== {e.q, e.busy, e.done}) begin
          n_fail++;
          $display("[TB] FAIL zero_hold mode=%b: actual q=%h b=%b d=%b required q=%h b=%b d=%b", modes[m], o_q, o_busy, o_done, e.q, e.busy, e.done);
        end
      end
    end
  endtask

  task automatic test_start_during_shift();
    exp_t e;
    int   it;
    i_sin_r = 1'b0;
    push_cmd(3'b001, 0, 8'h5A);
    @(posedge i_clk); #1; i_start = 1'b0;
    void'(exp_q.pop_front());
    push_cmd(3'b010, 4, 8'h00);
    push_idle();
    it = 0;
    while (exp_q.size() > 0) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if ({o_q, o_busy, o_done} !== {e.q, e.busy, e.done}) begin
        n_fail++;
        $display("[TB] FAIL start_in_shift: actual q=%h b=%b d=%b required q=%h b=%b d=%b", o_q, o_busy, o_done, e.q, e.busy, e.done);
      end
      it++;
      if (it == 2) begin
        i_start = 1'b1;
        i_mode  = 3'b001;
        i_d     = 8'hEE;
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   issued;
    i_sin_r = 1'b1;
    push_cmd(3'b010, 2, 8'h00);
    issued = 1'b0;
    while (exp_q.size() > 0) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if ({o_q, o_busy, o_done} !== {e.q, e.busy, e.done}) begin
        n_fail++;
        $display("[TB] FAIL back_to_back: actual q=%h b=%b d=%b required q=%h b=%b d=%b", o_q, o_busy, o_done, e.q, e.busy, e.done);
      end
      if (e.done && !issued) begin
        issued = 1'b1;
        push_cmd(3'b001, 0, 8'h11);
        push_idle();
      end
    end
    n_checks++;
    if (o_q !== 8'h11) begin
      n_fail++;
      $display("[TB] FAIL back_to_back_final: actual q=%h required q=11", o_q);
    end
    i_sin_r = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    exp_t e;
    i_sin_l = 1'b1;
    push_cmd(3'b011, 8, 8'h00);
    for (int k = 0; k < 4; k++) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if ({o_q, o_busy, o_done} !== {e.q, e.busy, e.done}) begin
        n_fail++;
        $display("[TB] FAIL pre_reset_shift: actual q=%h b=%b d=%b required q=%h b=%b d=%b", o_q, o_busy, o_done, e.q, e.busy, e.done);
      end
    end
    #2;
    i_rst = 1'b1;
    #1;
    n_checks++;
    if ({o_q, o_busy, o_done} !== {8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_shift: actual q=%h busy=%b done=%b required q=00 busy=0 done=0", o_q, o_busy, o_done);
    end
    exp_q.delete();
    model_q = 8'h00;
    @(negedge i_clk);
    i_rst   = 1'b0;
    i_sin_l = 1'b0;
    push_cmd(3'b001, 0, 8'hC6);
    push_cmd(3'b011, 1, 8'h00);
    i_mode   = 3'b001;
    i_amount = '0;
    push_idle();
    exp_q.delete();
    model_q = 8'hC6;
    push_cmd(3'b001, 0, 8'hC6);
    push_idle();
    while (exp_q.size() > 0) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if ({o_q, o_busy, o_done} !== {e.q, e.busy, e.done}) begin
        n_fail++;
        $display("[TB] FAIL post_reset_cmd: actual q=%h b=%b d=%b required q=%h b=%b d=%b", o_q, o_busy, o_done, e.q, e.busy, e.done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shift_left();
    test_shift_right();
    test_rotate();
    test_zero_and_hold();
    test_start_during_shift();
    test_back_to_back();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
